sram_req_bridge: RTL and testbench

//  Upstream front-end for sram_model: converts a valid/ready request channel into SRAM pin

---
 rtl/sram_bridge_pkg.sv | 31 +++
 rtl/sram_req_bridge_if.sv | 28 ++
 rtl/sram_req_bridge_fifo.sv | 60 ++++++
 rtl/sram_req_bridge.sv | 137 +++++++++++++
 tb/tb_sram_req_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the SRAM request bridge: widths, FSM states, stage and FIFO payloads.
package sram_bridge_pkg;

  localparam int ADDR_W          = 8;
  localparam int DATA_W          = 32;
  localparam int STRB_W          = DATA_W / 8;
  localparam int SRAM_DEPTH      = 256;
  localparam int RESP_FIFO_DEPTH = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              write;
    logic              err;
  } resp_t;

  typedef struct packed {
    logic write;
    logic err;
  } req_t;

  // Misaligned byte address or a word beyond the backed depth gets no SRAM access.
  function automatic logic addr_err(input logic [ADDR_W+1:0] byte_addr, input int depth);
    return (byte_addr[1:0] != 2'b00) || (int'(byte_addr[ADDR_W+1:2]) >= depth);
  endfunction

endpackage

// File: rtl/sram_req_bridge_if.sv
// Request/response valid-ready channels between an upstream master and the SRAM bridge.
interface sram_req_bridge_if;
  import sram_bridge_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W+1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_write;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_write, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_write, resp_err
  );

endinterface

// File: rtl/sram_req_bridge_fifo.sv
// Synchronous FIFO with occupancy count; data visible combinationally from registered storage.
// Push into a full FIFO is only taken alongside a pop, so count holds in that case.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic                         pop_vld_o,
  output logic [WIDTH-1:0]             pop_dat_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= wrap_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_vld_o = (count_q != '0);
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/sram_req_bridge.sv
// Zero-fills the SRAM after reset, then maps valid/ready requests onto SRAM pins; 3-cycle accept-to-response.
// Credit covers FIFO plus both pipeline stages, so resp_ready backpressure stalls req_ready without loss.
module sram_req_bridge
  import sram_bridge_pkg::*;
#(
  parameter int DEPTH      = SRAM_DEPTH,
  parameter int RESP_DEPTH = RESP_FIFO_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  sram_req_bridge_if.slave   bus,
  output logic               init_done,
  output logic [ADDR_W-1:0]  sram_adr,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic [STRB_W-1:0]  sram_wstrb,
  output logic [DATA_W-1:0]  sram_d,
  input  logic [DATA_W-1:0]  sram_q
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              init_done_q;
  logic [ADDR_W-1:0] sram_adr_q;
  logic              sram_cen_q;
  logic              sram_wen_q;
  logic [STRB_W-1:0] sram_wstrb_q;
  logic [DATA_W-1:0] sram_d_q;

  req_t              s1_d, s1_q, s2_q;
  logic              s1_vld_q, s2_vld_q;

  logic [ADDR_W-1:0] req_word;
  logic              req_err;
  logic              accept;
  logic              credit_ok;

  resp_t             push_d;
  resp_t             fifo_dat;
  logic              fifo_vld;
  logic [CNT_W-1:0]  fifo_count;

  assign req_word  = bus.req_addr[ADDR_W+1:2];
  assign req_err   = addr_err(bus.req_addr, DEPTH);
  assign credit_ok = (int'(fifo_count) + int'(s1_vld_q) + int'(s2_vld_q)) < RESP_DEPTH;
  // Gated by the registered init flag so no request can collide with the last sweep write.
  assign bus.req_ready = init_done_q && credit_ok;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      init_done_q  <= 1'b0;
      sram_adr_q   <= '0;
      sram_cen_q   <= 1'b0;
      sram_wen_q   <= 1'b0;
      sram_wstrb_q <= '0;
      sram_d_q     <= '0;
    end else begin
      case (state_q)
        INIT: begin
          sram_cen_q   <= 1'b1;
          sram_wen_q   <= 1'b1;
          sram_wstrb_q <= '1;
          sram_d_q     <= '0;
          sram_adr_q   <= ptr_q;
          ptr_q        <= ptr_q + 1'b1;
          if (ptr_q == ADDR_W'(DEPTH - 1)) state_q <= RUN;
        end
        RUN: begin
          init_done_q <= 1'b1;
          sram_cen_q  <= accept && !req_err;
          if (accept && !req_err) begin
            sram_adr_q   <= req_word;
            sram_wen_q   <= bus.req_write;
            sram_wstrb_q <= bus.req_write ? bus.req_wstrb : '0;
            if (bus.req_write) sram_d_q <= bus.req_wdata;
          end
        end
      endcase
    end
  end

  assign s1_d = '{write: bus.req_write, err: req_err};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      s1_vld_q <= accept;
      s1_q     <= s1_d;
      s2_vld_q <= s1_vld_q;
      s2_q     <= s1_q;
    end
  end

  // sram_q is only meaningful the cycle after a successful read, which is exactly S2.
  always_comb begin
    push_d       = '0;
    push_d.write = s2_q.write;
    push_d.err   = s2_q.err;
    push_d.rdata = (s2_q.write || s2_q.err) ? '0 : sram_q;
  end

  sync_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (s2_vld_q),
    .push_dat_i (push_d),
    .pop_i      (bus.resp_ready),
    .pop_vld_o  (fifo_vld),
    .pop_dat_o  (fifo_dat),
    .count_o    (fifo_count)
  );

  assign bus.resp_valid = fifo_vld;
  assign bus.resp_rdata = fifo_vld ? fifo_dat.rdata : '0;
  assign bus.resp_write = fifo_vld && fifo_dat.write;
  assign bus.resp_err   = fifo_vld && fifo_dat.err;

  assign init_done  = init_done_q;
  assign sram_adr   = sram_adr_q;
  assign sram_cen   = sram_cen_q;
  assign sram_wen   = sram_wen_q;
  assign sram_wstrb = sram_wstrb_q;
  assign sram_d     = sram_d_q;

endmodule

// File: tb/tb_sram_req_bridge.sv
// Bridge + behavioural SRAM; directed vector table, backpressure/reset sequences, random traffic vs a memory model.
module tb_sram_req_bridge;
  import sram_bridge_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              init_done;
  logic [ADDR_W-1:0] sram_adr;
  logic              sram_cen;
  logic              sram_wen;
  logic [STRB_W-1:0] sram_wstrb;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;

  int checks = 0;
  int errors = 0;

  sram_req_bridge_if bus ();

  sram_req_bridge dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .init_done  (init_done),
    .sram_adr   (sram_adr),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_wstrb (sram_wstrb),
    .sram_d     (sram_d),
    .sram_q     (sram_q)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  // Behavioural SRAM: contents scrambled during reset so only the zero-fill can clear them.
  logic [DATA_W-1:0] sram_mem [SRAM_DEPTH];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SRAM_DEPTH; i++) sram_mem[i] <= $urandom;
    end else if (sram_cen) begin
      if (sram_wen) begin
        for (int b = 0; b < STRB_W; b++)
          if (sram_wstrb[b]) sram_mem[sram_adr][8*b +: 8] <= sram_d[8*b +: 8];
      end else begin
        sram_q <= sram_mem[sram_adr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word-addressed memory plus in-order queue of expected responses.
  logic [DATA_W-1:0] ref_mem [SRAM_DEPTH];
  resp_t             exp_q [$];
  bit                hold_prev;
  resp_t             held;

  always @(negedge clock) begin
    resp_t got;
    resp_t e;
    int    w;
    got = '{rdata: bus.resp_rdata, write: bus.resp_write, err: bus.resp_err};
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < SRAM_DEPTH; i++) ref_mem[i] = '0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) check("resp_stable", {bus.resp_valid, got}, {1'b1, held});
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_extra: got response 0x%0h, want none (t=%0t)", got, $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_model", got, e);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        w = int'(bus.req_addr) / 4;
        if ((int'(bus.req_addr) % 4) != 0 || w >= SRAM_DEPTH) begin
          exp_q.push_back('{rdata: '0, write: bus.req_write, err: 1'b1});
        end else if (bus.req_write) begin
          for (int b = 0; b < STRB_W; b++)
            if (bus.req_wstrb[b]) ref_mem[w][8*b +: 8] = bus.req_wdata[8*b +: 8];
          exp_q.push_back('{rdata: '0, write: 1'b1, err: 1'b0});
        end else begin
          exp_q.push_back('{rdata: ref_mem[w], write: 1'b0, err: 1'b0});
        end
      end
      hold_prev = bus.resp_valid && !bus.resp_ready;
      held      = got;
    end
  end

  // Starts at posedge+1; returns at posedge+1 right after the accepting edge, valid still high.
  task automatic drive(input logic wr, input logic [9:0] a, input logic [31:0] wd, input logic [3:0] ws);
    bit ok;
    int n;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_wstrb = ws;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clock);
      if (bus.req_ready) ok = 1'b1;
      n++;
    end
    @(posedge clock); #1;
    check("req_accept", {63'd0, ok}, 64'd1);
  endtask

  task automatic txn(input logic wr, input logic [9:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output resp_t r, output int lat, output logic [5:0] slot);
    @(posedge clock); #1;
    drive(wr, a, wd, ws);
    bus.req_valid = 1'b0;
    lat  = 0;
    slot = '0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) slot = {sram_cen, sram_wen, sram_wstrb};
    end while (!bus.resp_valid && lat < 10);
    r = '{rdata: bus.resp_rdata, write: bus.resp_write, err: bus.resp_err};
  endtask

  task automatic drain(input string name);
    int n;
    @(posedge clock); #1;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.resp_valid) && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic reset_and_sweep();
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_state",
          {init_done, bus.req_ready, bus.resp_valid, sram_cen, sram_wen, sram_wstrb, sram_adr, sram_d},
          64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock);
    for (int k = 0; k < SRAM_DEPTH; k++) begin
      @(negedge clock);
      check($sformatf("sweep_%0d", k),
            {init_done, bus.req_ready, sram_cen, sram_wen, sram_wstrb, sram_d, sram_adr},
            {1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0, 8'(k)});
    end
    @(negedge clock);
    check("init_done_rise", {init_done, bus.req_ready, sram_cen}, 3'b110);
  endtask

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    resp_t       r;
    int          lat;
    logic [5:0]  slot;
    int          acc;
    int          nresp;
    int          cyc;
    bit          took;
    logic [9:0]  a;
    logic [9:0]  bp_addr [4];

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wstrb  = '0;
    bus.resp_ready = 1'b1;

    vecs[0]  = '{1'b1, 10'h040, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 10'h040, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 10'h044, 32'h11223344, 4'h5, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 10'h044, 32'h00000000, 4'h0, 32'h00220044, 1'b0};
    vecs[4]  = '{1'b0, 10'h042, 32'h00000000, 4'h0, 32'h00000000, 1'b1};
    vecs[5]  = '{1'b1, 10'h041, 32'h0BADF00D, 4'hF, 32'h00000000, 1'b1};
    vecs[6]  = '{1'b0, 10'h040, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b1, 10'h040, 32'hFFFFFFFF, 4'h0, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 10'h040, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 10'h3FC, 32'h00000000, 4'h0, 32'h00000000, 1'b0};
    vecs[10] = '{1'b1, 10'h3FC, 32'hA5A5A5A5, 4'hA, 32'h00000000, 1'b0};
    vecs[11] = '{1'b0, 10'h3FC, 32'h00000000, 4'h0, 32'hA500A500, 1'b0};

    reset_and_sweep();

    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r, lat, slot);
      check($sformatf("v%0d_latency", i), lat, 3);
      check($sformatf("v%0d_resp", i), r, {vecs[i].exp_rdata, vecs[i].wr, vecs[i].exp_err});
      if (vecs[i].exp_err)
        check($sformatf("v%0d_cen_idle", i), slot[5], 1'b0);
      else
        check($sformatf("v%0d_pins", i), slot,
              {1'b1, vecs[i].wr, vecs[i].wr ? vecs[i].wstrb : 4'h0});
    end

    // Back-to-back write/read on the same word: each read sees the write before it.
    @(posedge clock); #1;
    drive(1'b1, 10'h080, 32'hCAFEF00D, 4'hF);
    drive(1'b0, 10'h080, 32'h0, 4'h0);
    drive(1'b1, 10'h080, 32'h12345678, 4'h3);
    drive(1'b0, 10'h080, 32'h0, 4'h0);
    bus.req_valid = 1'b0;
    drain("raw_drain");

    // Backpressure: with resp_ready low, exactly RESP_DEPTH reads fit before req_ready drops.
    bp_addr[0] = 10'h040;
    bp_addr[1] = 10'h044;
    bp_addr[2] = 10'h3FC;
    bp_addr[3] = 10'h080;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = bp_addr[0];
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      took = bus.req_valid && bus.req_ready;
      if (took) acc++;
      @(posedge clock); #1;
      if (took) bus.req_addr = bp_addr[acc % 4];
    end
    check("bp_accepts", acc, RESP_FIFO_DEPTH);
    bus.req_valid = 1'b0;
    @(negedge clock);
    check("bp_ready_low", {bus.req_ready, bus.resp_valid}, 2'b01);
    @(posedge clock); #1;
    bus.resp_ready = 1'b1;
    nresp = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (bus.resp_valid && bus.resp_ready) nresp++;
    end
    check("bp_resps", nresp, RESP_FIFO_DEPTH);
    check("bp_queue_empty", exp_q.size(), 0);

    // Random traffic with random response backpressure.
    @(posedge clock); #1;
    acc  = 0;
    cyc  = 0;
    took = 1'b0;
    while (acc < 300 && cyc < 6000) begin
      if (!bus.req_valid || took) begin
        a = 10'(($urandom_range(0, 15) + ($urandom_range(0, 1) != 0 ? 240 : 0)) * 4);
        if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
        bus.req_valid = ($urandom_range(0, 3) != 0);
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = a;
        bus.req_wdata = $urandom;
        bus.req_wstrb = 4'($urandom_range(0, 15));
      end
      bus.resp_ready = ($urandom_range(0, 9) < 7);
      @(negedge clock);
      took = bus.req_valid && bus.req_ready;
      if (took) acc++;
      @(posedge clock); #1;
      cyc++;
    end
    check("rand_accepts", acc, 300);
    drain("rand_drain");

    // Reset with three reads outstanding and responses held back.
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
    drive(1'b0, 10'h040, 32'h0, 4'h0);
    drive(1'b0, 10'h044, 32'h0, 4'h0);
    drive(1'b0, 10'h3FC, 32'h0, 4'h0);
    bus.req_valid = 1'b0;
    cyc = 0;
    while (!bus.resp_valid && cyc < 10) begin
      @(negedge clock);
      cyc++;
    end
    check("rst_pre_valid", bus.resp_valid, 1'b1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst_flush", {bus.resp_valid, bus.req_ready, sram_cen}, 3'b000);
    reset_and_sweep();

    txn(1'b0, 10'h040, 32'h0, 4'h0, r, lat, slot);
    check("post_reset_read", r, {32'h0, 1'b0, 1'b0});
    check("post_reset_latency", lat, 3);
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
